// File: rtl/rv32_pkg.sv
// Shared RV32 pipeline definitions used by the fetch stage.
//   XLEN / INST_W : address and instruction widths
//   NOP           : canonical bubble (addi x0, x0, 0)
//   fetchEntry_t  : one buffered fetch result {pc, inst}
//   alignWord     : clears the byte-offset bits of an address
package rv32_pkg;
    localparam int XLEN   = 32;
    localparam int INST_W = 32;
    localparam logic [INST_W-1:0] NOP = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0]   pc;
        logic [INST_W-1:0] inst;
    } fetchEntry_t;

    function automatic logic [XLEN-1:0] alignWord(input logic [XLEN-1:0] addr);
        return addr & ~XLEN'(3);
    endfunction
endpackage

// File: rtl/ifetch_fifo.sv
// Instruction buffer between imem responses and decode.
// DEPTH entries of {pc, inst}; all outputs come straight from flops, so a
// push is visible at the head one cycle later.
//   clk, rst_n     : clock, synchronous active-low reset
//   flush          : drop every entry (wins over push/pop)
//   push, pushData : write one entry (caller guarantees space)
//   pop            : retire the head entry (ignored when empty)
//   headValid      : head entry holds data
//   headData       : head entry
//   count          : entries held, 0..DEPTH
module ifetch_fifo
    import rv32_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         flush,
    input  logic                         push,
    input  fetchEntry_t                  pushData,
    input  logic                         pop,
    output logic                         headValid,
    output fetchEntry_t                  headData,
    output logic [$clog2(DEPTH):0]       count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    fetchEntry_t    mem [DEPTH];
    logic [PW-1:0]  rdPtr;
    logic [PW-1:0]  wrPtr;
    logic           doPop;

    assign doPop = pop && (count != '0);

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            rdPtr <= '0;
            wrPtr <= '0;
            count <= '0;
        end else begin
            if (push)  wrPtr <= wrPtr + PW'(1);
            if (doPop) rdPtr <= rdPtr + PW'(1);
            case ({push, doPop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: ;
            endcase
        end
    end

    // Storage needs no reset; validity is carried entirely by count.
    always_ff @(posedge clk) begin
        if (push) mem[wrPtr] <= pushData;
    end

    assign headValid = (count != '0);
    assign headData  = mem[rdPtr];
endmodule

// File: rtl/ifetch_unit.sv
// RV32 instruction fetch stage: owns the PC, issues word fetches on a
// valid/ready channel, buffers in-order responses and hands them to decode.
// A redirect flushes the buffer and discards responses still in flight.
//   clk, rst_n                  : clock, synchronous active-low reset
//   pcSel, alu_target           : redirect request and target
//   stall                       : decode cannot take inst this cycle
//   imem_req_valid/ready/addr   : fetch request channel
//   imem_rsp_valid/data         : in-order fetch responses (no back-pressure)
//   inst_valid, inst, inst_pc   : instruction to decode (NOP when invalid)
module ifetch_unit
    import rv32_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
    parameter int              DEPTH    = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pcSel,
    input  logic [XLEN-1:0]   alu_target,
    input  logic              stall,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [XLEN-1:0]   imem_req_addr,
    input  logic              imem_rsp_valid,
    input  logic [INST_W-1:0] imem_rsp_data,
    output logic              inst_valid,
    output logic [INST_W-1:0] inst,
    output logic [XLEN-1:0]   inst_pc
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW:0] DEPTH_SUM = (CW+1)'(DEPTH);

    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rspPc;        // PC of the next response that will be kept
    logic [XLEN-1:0] target;
    logic [CW-1:0]   outstanding;
    logic [CW-1:0]   outstandingNext;
    logic [CW-1:0]   dropCnt;
    logic [CW-1:0]   count;
    logic            reqAccept;
    logic            rspKeep;
    logic            rspDrop;
    logic            push;
    logic            pop;
    logic            headValid;
    fetchEntry_t     headData;
    fetchEntry_t     pushData;

    assign target = alignWord(alu_target);

    // Every request in flight owns a buffer slot, so a response can always be pushed.
    // rst_n gating keeps the request channel quiet while held in reset.
    assign imem_req_valid = rst_n && (({1'b0, outstanding} + {1'b0, count}) < DEPTH_SUM);
    assign imem_req_addr  = pc;

    assign reqAccept       = imem_req_valid && imem_req_ready;
    assign rspDrop         = imem_rsp_valid && (dropCnt != '0);
    assign rspKeep         = imem_rsp_valid && (dropCnt == '0);
    assign outstandingNext = outstanding + CW'(reqAccept) - CW'(imem_rsp_valid);

    assign push     = rspKeep && !pcSel;
    assign pop      = headValid && !stall && !pcSel;
    assign pushData = '{pc: rspPc, inst: imem_rsp_data};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc          <= RESET_PC;
            rspPc       <= RESET_PC;
            outstanding <= '0;
            dropCnt     <= '0;
        end else begin
            outstanding <= outstandingNext;
            if (pcSel) begin
                // Everything still in flight after this cycle, including a
                // request accepted right now at the old pc, is wrong-path.
                pc      <= target;
                rspPc   <= target;
                dropCnt <= outstandingNext;
            end else begin
                if (reqAccept) pc      <= pc + XLEN'(4);
                if (rspKeep)   rspPc   <= rspPc + XLEN'(4);
                if (rspDrop)   dropCnt <= dropCnt - CW'(1);
            end
        end
    end

    ifetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (pcSel),
        .push      (push),
        .pushData  (pushData),
        .pop       (pop),
        .headValid (headValid),
        .headData  (headData),
        .count     (count)
    );

    assign inst_valid = headValid;
    assign inst       = headValid ? headData.inst : NOP;
    assign inst_pc    = headValid ? headData.pc   : rspPc;
endmodule

// File: tb/tb_ifetch_unit.sv
// Self-checking bench for ifetch_unit. A behavioural memory (in-order,
// variable latency) answers requests; a scoreboard tracks the expected
// program-order PC stream and the expected next fetch address.
module tb_ifetch_unit;
    import rv32_pkg::*;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] WRAP_PC  = 32'hFFFF_FFF8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // main instance
    logic        rst_n = 1'b0;
    logic        pcSel = 1'b0;
    logic [31:0] alu_target = '0;
    logic        stall = 1'b0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;

    // wrap instance (RESET_PC near the top of the address space, DEPTH 2)
    logic        wRst = 1'b0;
    logic        wPcSel = 1'b0;
    logic [31:0] wTarget = '0;
    logic        wStall = 1'b0;
    logic        wReqValid;
    logic        wReqReady = 1'b1;
    logic [31:0] wReqAddr;
    logic        wRspValid = 1'b0;
    logic [31:0] wRspData = '0;
    logic        wInstValid;
    logic [31:0] wInst;
    logic [31:0] wInstPc;

    ifetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .pcSel(pcSel), .alu_target(alu_target), .stall(stall),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc)
    );

    ifetch_unit #(.RESET_PC(WRAP_PC), .DEPTH(2)) dutWrap (
        .clk(clk), .rst_n(wRst), .pcSel(wPcSel), .alu_target(wTarget), .stall(wStall),
        .imem_req_valid(wReqValid), .imem_req_ready(wReqReady), .imem_req_addr(wReqAddr),
        .imem_rsp_valid(wRspValid), .imem_rsp_data(wRspData),
        .inst_valid(wInstValid), .inst(wInst), .inst_pc(wInstPc)
    );

    typedef struct {
        logic [31:0] addr;
        int          due;
    } memReq_t;

    memReq_t     rspQ[$];
    int          cyc, lat, lastDue, readyMode;
    int          passCnt = 0;
    int          totalCnt = 0;
    logic [31:0] expPc, expReqPc, lastAccAddr;
    bit          lastAcc, lastRsp, redirPrev;
    int          firstAccCyc, firstValidCyc, consumedCnt;

    function automatic logic [31:0] memData(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5EED_C0DE;
    endfunction

    // One clock of the environment: observe outputs at the falling edge,
    // score them, then answer/accept and drive the next inputs.
    task automatic cycle(input bit stallIn, input bit selIn, input logic [31:0] tgt);
        int      inflight;
        int      due;
        memReq_t r;
        @(negedge clk);
        cyc++;
        if (redirPrev) begin
            totalCnt++;
            if (inst_valid !== 1'b0) $display("FAIL redirect_bubble: inst_valid=%b expected 0", inst_valid);
            else passCnt++;
        end
        if (inst_valid === 1'b1) begin
            if (firstValidCyc < 0) firstValidCyc = cyc;
            totalCnt++;
            if (inst_pc !== expPc) $display("FAIL inst_pc: got %h expected %h", inst_pc, expPc);
            else passCnt++;
            totalCnt++;
            if (inst !== memData(expPc)) $display("FAIL inst_data: got %h expected %h", inst, memData(expPc));
            else passCnt++;
        end else begin
            totalCnt++;
            if (inst !== NOP) $display("FAIL inst_nop: got %h expected %h", inst, NOP);
            else passCnt++;
        end
        inflight       = rspQ.size();
        lastRsp        = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        if (rspQ.size() > 0 && rspQ[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = memData(rspQ[0].addr);
            void'(rspQ.pop_front());
            lastRsp = 1'b1;
        end
        imem_req_ready = (readyMode == 1) ? 1'b1 : 1'($urandom_range(0, 1));
        lastAcc = imem_req_valid && imem_req_ready;
        if (lastAcc) begin
            totalCnt++;
            if (imem_req_addr !== expReqPc) $display("FAIL req_addr: got %h expected %h", imem_req_addr, expReqPc);
            else passCnt++;
            totalCnt++;
            if (inflight >= DEPTH) $display("FAIL credit: accepted with %0d in flight, limit %0d", inflight, DEPTH);
            else passCnt++;
            due     = (cyc + lat > lastDue) ? cyc + lat : lastDue + 1;
            r.addr  = expReqPc;
            r.due   = due;
            rspQ.push_back(r);
            lastDue     = due;
            lastAccAddr = imem_req_addr;
            expReqPc    = expReqPc + 32'd4;
            if (firstAccCyc < 0) firstAccCyc = cyc;
        end
        stall      = stallIn;
        pcSel      = selIn && inst_valid;
        alu_target = tgt;
        redirPrev  = pcSel;
        if (pcSel) begin
            expPc    = tgt & 32'hFFFF_FFFC;
            expReqPc = tgt & 32'hFFFF_FFFC;
        end else if (inst_valid && !stallIn) begin
            expPc = expPc + 32'd4;
            consumedCnt++;
        end
    endtask

    task automatic doReset();
        @(negedge clk);
        rst_n = 1'b0; pcSel = 1'b0; stall = 1'b0; alu_target = '0;
        imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
        @(negedge clk);
        totalCnt++;
        if (inst_valid !== 1'b0) $display("FAIL reset_inst_valid: got %b expected 0", inst_valid); else passCnt++;
        totalCnt++;
        if (inst !== NOP) $display("FAIL reset_inst: got %h expected %h", inst, NOP); else passCnt++;
        totalCnt++;
        if (inst_pc !== RESET_PC) $display("FAIL reset_inst_pc: got %h expected %h", inst_pc, RESET_PC); else passCnt++;
        totalCnt++;
        if (imem_req_valid !== 1'b0) $display("FAIL reset_req_valid: got %b expected 0", imem_req_valid); else passCnt++;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        rspQ.delete();
        cyc = 0; lastDue = 0; redirPrev = 1'b0;
        expPc = RESET_PC; expReqPc = RESET_PC;
        firstAccCyc = -1; firstValidCyc = -1; consumedCnt = 0;
    endtask

    task automatic test_reset();
        lat = 1; readyMode = 1;
        doReset();
        repeat (12) cycle(1'b0, 1'b0, '0);
        totalCnt++;
        if (firstAccCyc != 1) $display("FAIL first_accept_cycle: got %0d expected 1", firstAccCyc); else passCnt++;
        totalCnt++;
        if (firstValidCyc - firstAccCyc != 2)
            $display("FAIL first_latency: got %0d expected 2", firstValidCyc - firstAccCyc);
        else passCnt++;
        totalCnt++;
        if (consumedCnt != 10) $display("FAIL throughput: got %0d expected 10", consumedCnt); else passCnt++;
    endtask

    task automatic test_stall();
        lat = 1; readyMode = 1;
        doReset();
        repeat (4) cycle(1'b0, 1'b0, '0);
        repeat (5) cycle(1'b1, 1'b0, '0);
        totalCnt++;
        if (imem_req_valid !== 1'b0) $display("FAIL stall_full: req_valid=%b expected 0", imem_req_valid); else passCnt++;
        totalCnt++;
        if (inst_valid !== 1'b1) $display("FAIL stall_hold: inst_valid=%b expected 1", inst_valid); else passCnt++;
        repeat (14) cycle(1'b0, 1'b0, '0);
        totalCnt++;
        if (consumedCnt != 16) $display("FAIL stall_count: got %0d expected 16", consumedCnt); else passCnt++;
    endtask

    task automatic test_redirect_inflight();
        lat = 3; readyMode = 1;
        doReset();
        for (int i = 0; i < 20; i++) begin
            cycle(1'b0, 1'b1, 32'h100);
            if (redirPrev) break;
        end
        totalCnt++;
        if (!redirPrev) $display("FAIL redir_issue: no valid instruction within 20 cycles");
        else passCnt++;
        totalCnt++;
        if (rspQ.size() < 2) $display("FAIL redir_inflight: got %0d expected at least 2", rspQ.size()); else passCnt++;
        for (int i = 0; i < 30; i++) begin
            cycle(1'b0, 1'b0, '0);
            if (inst_valid === 1'b1) break;
        end
        totalCnt++;
        if (inst_valid !== 1'b1 || inst_pc !== 32'h100)
            $display("FAIL redir_target: inst_valid=%b inst_pc=%h expected 1/00000100", inst_valid, inst_pc);
        else passCnt++;
        repeat (10) cycle(1'b0, 1'b0, '0);
    endtask

    task automatic test_redirect_coincide();
        lat = 1; readyMode = 1;
        doReset();
        repeat (5) cycle(1'b0, 1'b0, '0);
        cycle(1'b0, 1'b1, 32'h0000_0203);
        totalCnt++;
        if (!(lastAcc && lastRsp && redirPrev))
            $display("FAIL coincide_setup: acc=%b rsp=%b redir=%b expected 1/1/1", lastAcc, lastRsp, redirPrev);
        else passCnt++;
        for (int i = 0; i < 10; i++) begin
            cycle(1'b0, 1'b0, '0);
            if (lastAcc) break;
        end
        totalCnt++;
        if (!lastAcc || lastAccAddr !== 32'h200)
            $display("FAIL misaligned_target: acc=%b addr=%h expected 1/00000200", lastAcc, lastAccAddr);
        else passCnt++;
        repeat (12) cycle(1'b0, 1'b0, '0);
    endtask

    task automatic test_random();
        bit          st, sel;
        logic [31:0] tgt;
        readyMode = 0; lat = 1;
        doReset();
        for (int i = 0; i < 600; i++) begin
            if (i % 60 == 0) lat = $urandom_range(1, 4);
            st  = ($urandom_range(0, 3) == 0);
            sel = ($urandom_range(0, 11) == 0);
            tgt = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF4 : $urandom;
            cycle(st, sel, tgt);
        end
        totalCnt++;
        if (consumedCnt < 50) $display("FAIL random_progress: consumed %0d expected at least 50", consumedCnt);
        else passCnt++;
    endtask

    task automatic test_mid_reset();
        lat = 1; readyMode = 1;
        doReset();
        repeat (3) cycle(1'b0, 1'b0, '0);
        repeat (8) cycle(1'b1, 1'b0, '0);
        totalCnt++;
        if (imem_req_valid !== 1'b0) $display("FAIL midreset_full: req_valid=%b expected 0", imem_req_valid); else passCnt++;
        doReset();
        cycle(1'b0, 1'b0, '0);
        totalCnt++;
        if (!lastAcc || lastAccAddr !== RESET_PC)
            $display("FAIL midreset_refetch: acc=%b addr=%h expected 1/%h", lastAcc, lastAccAddr, RESET_PC);
        else passCnt++;
        repeat (8) cycle(1'b0, 1'b0, '0);
    endtask

    task automatic test_wrap();
        bit          accPrev;
        logic [31:0] addrPrev, e;
        int          nAcc, nInst;
        @(negedge clk);
        wRst = 1'b0; wRspValid = 1'b0;
        repeat (2) @(negedge clk);
        totalCnt++;
        if (wInstValid !== 1'b0 || wReqValid !== 1'b0)
            $display("FAIL wrap_reset: inst_valid=%b req_valid=%b expected 0/0", wInstValid, wReqValid);
        else passCnt++;
        @(posedge clk);
        #1;
        wRst = 1'b1;
        accPrev = 1'b0; addrPrev = '0; nAcc = 0; nInst = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            wRspValid = accPrev;
            wRspData  = memData(addrPrev);
            if (wInstValid === 1'b1) begin
                e = WRAP_PC + 32'(nInst * 4);
                totalCnt++;
                if (wInstPc !== e || wInst !== memData(e))
                    $display("FAIL wrap_inst: pc=%h inst=%h expected %h/%h", wInstPc, wInst, e, memData(e));
                else passCnt++;
                nInst++;
            end
            accPrev  = wReqValid;
            addrPrev = wReqAddr;
            if (wReqValid === 1'b1) begin
                e = WRAP_PC + 32'(nAcc * 4);
                if (nAcc < 3) begin
                    totalCnt++;
                    if (wReqAddr !== e) $display("FAIL wrap_req_addr: got %h expected %h", wReqAddr, e);
                    else passCnt++;
                end
                nAcc++;
            end
        end
        totalCnt++;
        if (nAcc < 3 || nInst < 3) $display("FAIL wrap_progress: accepts=%0d insts=%0d expected >=3 each", nAcc, nInst);
        else passCnt++;
    endtask

    initial begin
        test_reset();
        test_stall();
        test_redirect_inflight();
        test_redirect_coincide();
        test_random();
        test_mid_reset();
        test_wrap();
        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end
endmodule

// File: doc/ifetch_unit.md
# ifetch_unit

Instruction fetch stage for the RV32 pipeline. It produces the `inst` word consumed by the control/decode stage and accepts that stage's `pcSel` redirect together with the ALU-computed target. It owns the program counter and drives a valid/ready request channel to instruction memory. In-order responses are buffered in a small FIFO, so fetch continues while decode is stalled. A redirect flushes wrong-path instructions, including responses still in flight.

## Interface
Parameters:
- `RESET_PC`, default `32'h0000_0000`: PC of the first fetch after reset.
- `DEPTH`, default 2: instruction FIFO entries; also the outstanding-request limit. Power of two, at least 2.

Ports:
- `clk` in 1: the single clock.
- `rst_n` in 1: synchronous, active-low reset.
- `pcSel` in 1: redirect request from control; 1 means take `alu_target`.
- `alu_target` in 32: redirect target address.
- `stall` in 1: decode cannot accept `inst` this cycle.
- `imem_req_valid` out 1: fetch request valid.
- `imem_req_ready` in 1: memory accepts the request.
- `imem_req_addr` out 32: word-aligned fetch address.
- `imem_rsp_valid` in 1: response valid. Responses arrive in order, at least 1 cycle after acceptance, and are never back-pressured.
- `imem_rsp_data` in 32: instruction word.
- `inst_valid` out 1: `inst` and `inst_pc` hold a real instruction.
- `inst` out 32: instruction to control. Equals `NOP` (`32'h0000_0013`) whenever `inst_valid` is 0.
- `inst_pc` out 32: PC of `inst`.

## Operation
- Registers:
  - `pc`: next address to request.
  - `outstanding`: accepted requests not yet responded, 0..DEPTH.
  - `drop_cnt`: in-flight responses to discard, 0..DEPTH.
  - FIFO of {pc, inst} with `count`.
- Request issue:
  - `imem_req_valid = (outstanding + count < DEPTH)`.
  - `imem_req_addr = pc`.
  - On accept (valid & ready), `pc <= pc + 4`, wrapping modulo 2^32 (`32'hFFFF_FFFC + 4 = 0`), and `outstanding` increments.
- Response handling:
  - On `imem_rsp_valid`, `outstanding` decrements.
  - If `drop_cnt > 0`, the response is discarded and `drop_cnt` decrements.
  - Otherwise {pc of that request, data} is pushed. The credit rule guarantees space.
  - Request PCs are tracked in a parallel PC FIFO, or recomputed from a registered response-PC counter.
- Consume: a pop occurs when `inst_valid & !stall`.
- Redirect (`pcSel=1`) has priority over every other event in the same cycle:
  - The FIFO is cleared; any pop or push that cycle is void.
  - `pc <= {alu_target[31:2], 2'b00}`.
  - `drop_cnt <= outstanding + req_accept - rsp_valid_this_cycle`. A request accepted in the redirect cycle fetches `pc` and is wrong-path.
  - `imem_req_valid` may stay high while the address changes. The memory samples the address only on accept.
- Simultaneous events:
  - Push and pop in the same cycle leave `count` unchanged.
  - Accept and response in the same cycle leave `outstanding` unchanged.
- `pcSel` is only meaningful when `inst_valid`. Control guarantees this; the block still honours it unconditionally.

## Timing
- Reset values (`rst_n=0` at a rising edge):
  - `pc = RESET_PC`, `outstanding = 0`, `drop_cnt = 0`, `count = 0`.
  - `inst_valid = 0`, `inst = NOP`, `inst_pc = RESET_PC`, `imem_req_valid = 0`.
- Reset mid-operation discards everything. Responses to pre-reset requests are not expected; the memory is reset together with this block.
- `imem_req_valid` may rise in the first cycle after reset release.
- Latency: a request accepted in cycle N with the response in N+1 gives `inst_valid` in N+2, because the FIFO head is registered.
- Throughput: 1 instruction per cycle when memory latency is 1 and there is no stall.
- Redirect in cycle N: `inst_valid = 0` in N+1, and the first request at the target is offered in N+1.
- Full condition: with `count = DEPTH`, or `outstanding + count = DEPTH`, `imem_req_valid` is 0.

## Structure
- Shared package `rv32_pkg`: `XLEN = 32`, `NOP = 32'h0000_0013`, and `INST_W`.
- Sub-module `ifetch_fifo`: synchronous FIFO, DEPTH × 64 bits, with a `flush` input and registered head output. It carries {pc, inst}.
- All remaining logic lives at top level: PC, credit and drop counters.

## Test plan
- **Reset and first fetch:** release `rst_n` with 1-cycle memory and `stall=0` → requests at 0, 4, 8; `inst_valid` 2 cycles after the first accept; `inst_pc` sequence 0, 4, 8.
- **Stall/back-pressure:** hold `stall=1` for 5 cycles → at most DEPTH entries buffered, `imem_req_valid=0` once full, no instruction lost or duplicated after release.
- **Redirect with in-flight requests:** 3-cycle memory latency, `pcSel=1` with `alu_target=32'h100` while 2 requests are outstanding → both old responses dropped; the next `inst_valid` carries `inst_pc = 32'h100`.
- **Redirect coinciding with response and accept in the same cycle** → `drop_cnt` is computed correctly; no stale instruction appears.
- **Misaligned target and wrap:** `alu_target=32'h0000_0203` → request at `32'h200`. Start at `RESET_PC=32'hFFFF_FFF8` → requests F8, FC, 0.
- **Mid-operation reset** with a full FIFO → the next cycle shows `inst_valid=0`, `inst=NOP`, and refetch from `RESET_PC`.
